apb_master: RTL

Command-driven APB initiator for the matmul accelerator's host side. It takes single read/write commands over a valid/ready interface and runs the APB setup/access sequence. It handles wait states, error retry with backoff, and an access timeout, then returns one response per command. It is the counterpart of the accelerator's APB slave and drives that slave directly in system benches and in the SoC wrapper.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 28 ++
 rtl/apb_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the host-side APB initiator: FSM state encoding and the
// accelerator's register map as seen from the bus.
package apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } apb_state_t;

    // Accelerator register offsets (byte addresses)
    localparam logic [7:0] REG_CONTROL   = 8'h00;
    localparam logic [7:0] REG_OPERAND_A = 8'h04;
    localparam logic [7:0] REG_OPERAND_B = 8'h08;
    localparam logic [7:0] REG_FLAGS     = 8'h0C;
    localparam logic [7:0] REG_SP_FIRST  = 8'h10;
    localparam logic [7:0] REG_SP_LAST   = 8'h1C;

    // Operand row select lives in addr[6:5]
    localparam int OPROW_LSB = 5;
    localparam int OPROW_MSB = 6;

    localparam logic [3:0] RETRY_SAT = 4'd15;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable saturating down-counter shared by the ACCESS timeout and the BACKOFF delay.
// expired is high whenever the count is zero; load takes priority over count.
module apb_wait_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             count,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/apb_master.sv
// Command-driven APB initiator: accept -> SETUP -> ACCESS (+1 cycle per wait state) -> response,
// with PSLVERR retry/backoff and ACCESS timeout; cmd_ready_o stays low until the response is taken.
module apb_master
    import apb_pkg::*;
#(
    parameter int  DATA_WIDTH     = 8,
    parameter int  BUS_WIDTH      = 32,
    parameter int  ADDR_WIDTH     = 16,
    parameter int  TIMEOUT_CYCLES = 64,
    parameter int  RETRY_MAX      = 2,
    parameter int  BACKOFF_CYCLES = 4,
    localparam int STRB_WIDTH     = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [3:0]            rsp_retries_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

    // The timer holds "cycles remaining minus one", so expired marks the last allowed cycle
    localparam logic [TMR_W-1:0] TO_LOAD   = TO_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TMR_W-1:0] BO_LOAD   = TMR_W'(BACKOFF_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);

    apb_state_t       state_q, state_d;
    logic             accept;
    logic             done_ok, done_err, done_to, retry;
    logic             tmr_load, tmr_count, tmr_expired;
    logic [TMR_W-1:0] tmr_value;

    apb_wait_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .load    (tmr_load),
        .value   (tmr_value),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        done_to   = 1'b0;
        retry     = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = TO_LOAD;
        tmr_count = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                tmr_load  = 1'b1;
                tmr_value = TO_LOAD;
            end
            ST_ACCESS: begin
                // PSLVERR counts as completion even without PREADY: the accelerator signals busy this way
                if (pslverr_i) begin
                    if (rsp_retries_o < RETRY_LIM) begin
                        retry     = 1'b1;
                        state_d   = ST_BACKOFF;
                        tmr_load  = 1'b1;
                        tmr_value = BO_LOAD;
                    end else begin
                        done_err = 1'b1;
                        state_d  = ST_RESP;
                    end
                end else if (pready_i) begin
                    done_ok = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN && tmr_expired) begin
                    done_to = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (tmr_expired) begin
                    state_d = ST_SETUP;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs are registered; bus controls are decoded from the next state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_retries_o <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
        end else begin
            cmd_ready_o <= (state_d == ST_IDLE);
            rsp_valid_o <= (state_d == ST_RESP);
            psel_o      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_o   <= (state_d == ST_ACCESS);

            if (accept) begin
                pwrite_o      <= cmd_write_i;
                paddr_o       <= cmd_addr_i;
                pwdata_o      <= cmd_wdata_i;
                pstrb_o       <= cmd_write_i ? cmd_strb_i : '0;
                rsp_retries_o <= '0;
                rsp_err_o     <= 1'b0;
                rsp_timeout_o <= 1'b0;
                rsp_rdata_o   <= '0;
            end

            if (retry && (rsp_retries_o != RETRY_SAT)) begin
                rsp_retries_o <= rsp_retries_o + 4'd1;
            end

            if (done_ok) begin
                rsp_err_o     <= 1'b0;
                rsp_timeout_o <= 1'b0;
                rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            end

            if (done_err || done_to) begin
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= done_to;
                rsp_rdata_o   <= '0;
            end
        end
    end

endmodule
